// File: rtl/seq_priority_encoder.sv
// Captures a multi-hot vector and emits its set-bit codes lowest-first, one beat each; out_valid follows capture by 1 cycle.
// Beats hold on out_ready low; in_ready stays low until the last beat of the captured vector transfers.
module seq_priority_encoder #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [0:2**N-1]  y,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N-1:0]     w,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             out_none
);

   localparam int VW = 2**N;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t          state, state_n;
   logic [VW-1:0]   pend, pend_n;
   logic [N-1:0]    low_idx;
   logic            emit;

   // Scanning from the top down lets the lowest set index win.
   function automatic logic [N-1:0] lowest_set(input logic [VW-1:0] v);
      logic [N-1:0] idx;
      idx = '0;
      for (int i = VW - 1; i >= 0; i--) begin
         if (v[i]) idx = N'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_n;
         pend  <= pend_n;
      end
   end

   always_comb begin
      state_n   = state;
      pend_n    = pend;
      emit      = (state == EMIT);
      low_idx   = lowest_set(pend);
      in_ready  = (state == IDLE) && en && !rst;
      out_valid = emit;
      w         = emit ? low_idx : '0;
      out_last  = emit && $onehot0(pend);
      // An empty pending register in EMIT can only come from an all-zero capture.
      out_none  = emit && (pend == '0);

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               for (int i = 0; i < VW; i++) pend_n[i] = y[i];
               state_n = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pend_n[low_idx] = 1'b0;
               if (out_last) begin
                  pend_n  = '0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            pend_n  = '0;
         end
      endcase
   end

endmodule
